// File: rtl/seq_divider.sv
// rtl/seq_divider.sv - sequential restoring divider (DIV/DIVU), one quotient bit per clock
module seq_divider #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 5
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             Start,
    input  logic             Signed,
    input  logic [WIDTH-1:0] Dividend,
    input  logic [WIDTH-1:0] Divisor,
    output logic             Busy,
    output logic             Done,
    output logic [WIDTH-1:0] Quotient,
    output logic [WIDTH-1:0] Remainder,
    output logic             DivZero
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_FIX  = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_next_state;
    logic               w_load;
    logic               w_iter;
    logic               w_finish;

    logic               r_busy;
    logic               r_done;
    logic [WIDTH-1:0]   r_quot;
    logic [WIDTH-1:0]   r_rem;
    logic               r_divzero;

    // Working registers. The partial remainder is conceptually WIDTH+1 bits,
    // but after every iteration it is strictly below the divisor magnitude,
    // so its top bit is always zero and only WIDTH bits are stored.
    logic [WIDTH-1:0]   r_q;
    logic [WIDTH-1:0]   r_d;
    logic [WIDTH-1:0]   r_p;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_negq;
    logic               r_negr;
    logic               r_dz;
    logic [WIDTH-1:0]   r_dividend_raw;

    logic               w_dvd_neg;
    logic               w_dvs_neg;
    logic [WIDTH-1:0]   w_dividend_abs;
    logic [WIDTH-1:0]   w_divisor_abs;
    logic [WIDTH:0]     w_shift;
    logic [WIDTH:0]     w_trial;
    logic               w_take;
    logic [WIDTH-1:0]   w_quot_fix;
    logic [WIDTH-1:0]   w_rem_fix;

    // Operand magnitudes; unsigned requests pass the raw values through.
    always_comb begin
        w_dvd_neg      = Signed & Dividend[WIDTH-1];
        w_dvs_neg      = Signed & Divisor[WIDTH-1];
        w_dividend_abs = w_dvd_neg ? (-Dividend) : Dividend;
        w_divisor_abs  = w_dvs_neg ? (-Divisor) : Divisor;
    end

    // One restoring step: shift {P,Q} left, trial-subtract D, keep if non-negative.
    always_comb begin
        w_shift = {r_p, r_q[WIDTH-1]};
        w_trial = w_shift - {1'b0, r_d};
        w_take  = ~w_trial[WIDTH];
    end

    // Sign correction applied when the result is published.
    always_comb begin
        w_quot_fix = r_negq ? (-r_q) : r_q;
        w_rem_fix  = r_negr ? (-r_p) : r_p;
    end

    // State register plus a registered Busy that tracks the upcoming state.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
        end else begin
            r_state <= w_next_state;
            r_busy  <= (w_next_state != S_IDLE);
        end
    end

    // Next-state logic and per-state datapath strobes.
    always_comb begin
        w_next_state = r_state;
        w_load       = 1'b0;
        w_iter       = 1'b0;
        w_finish     = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (Start) begin
                    w_next_state = S_RUN;
                    w_load       = 1'b1;
                end
            end
            S_RUN: begin
                w_iter = 1'b1;
                if (r_cnt == '0) begin
                    w_next_state = S_FIX;
                end
            end
            S_FIX: begin
                w_finish     = 1'b1;
                w_next_state = S_IDLE;
            end
            default: begin
                w_next_state = S_IDLE;
            end
        endcase
    end

    // Datapath: operand capture, iteration, and result publication.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_q            <= '0;
            r_d            <= '0;
            r_p            <= '0;
            r_cnt          <= '0;
            r_negq         <= 1'b0;
            r_negr         <= 1'b0;
            r_dz           <= 1'b0;
            r_dividend_raw <= '0;
            r_quot         <= '0;
            r_rem          <= '0;
            r_divzero      <= 1'b0;
            r_done         <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (w_load) begin
                r_q            <= w_dividend_abs;
                r_d            <= w_divisor_abs;
                r_p            <= '0;
                r_cnt          <= CNT_W'(WIDTH - 1);
                r_negq         <= w_dvd_neg ^ w_dvs_neg;
                r_negr         <= w_dvd_neg;
                r_dz           <= (Divisor == '0);
                r_dividend_raw <= Dividend;
            end
            if (w_iter) begin
                if (w_take) begin
                    r_p <= w_trial[WIDTH-1:0];
                    r_q <= {r_q[WIDTH-2:0], 1'b1};
                end else begin
                    r_p <= w_shift[WIDTH-1:0];
                    r_q <= {r_q[WIDTH-2:0], 1'b0};
                end
                r_cnt <= r_cnt - 1'b1;
            end
            if (w_finish) begin
                r_done <= 1'b1;
                if (r_dz) begin
                    // Divide by zero: all-ones quotient, untouched dividend as remainder.
                    r_quot    <= '1;
                    r_rem     <= r_dividend_raw;
                    r_divzero <= 1'b1;
                end else begin
                    r_quot    <= w_quot_fix;
                    r_rem     <= w_rem_fix;
                    r_divzero <= 1'b0;
                end
            end
        end
    end

    assign Busy      = r_busy;
    assign Done      = r_done;
    assign Quotient  = r_quot;
    assign Remainder = r_rem;
    assign DivZero   = r_divzero;

endmodule

// File: doc/seq_divider.md
Name: seq_divider

Overview:
Sequential restoring divider for the CPU's DIV/DIVU path. It retires one quotient bit per clock. It is the inverse-operation counterpart of the shift-add multiplier: it shifts left and subtracts, where the multiplier shifts right and adds.
- Control FSM and datapath live in this one module.
- Quotient goes to LO and remainder goes to HI in the execute stage.
- The CPU side uses a Start/Busy/Done handshake.

Parameters:
WIDTH, 32, operand/result width in bits (WIDTH >= 2)
CNT_W, 5, iteration counter width; must satisfy 2**CNT_W >= WIDTH

Ports:
Clk  input  1  system clock, rising-edge
Reset  input  1  synchronous, active-high reset
Start  input  1  request a division; sampled only in IDLE
Signed  input  1  1 = DIV (two's complement), 0 = DIVU; sampled with Start
Dividend  input  WIDTH  numerator; sampled with Start
Divisor  input  WIDTH  denominator; sampled with Start
Busy  output  1  operation in progress (RUN or FIX)
Done  output  1  one-cycle pulse: Quotient/Remainder/DivZero valid and updated
Quotient  output  WIDTH  result quotient (LO); held until next Done
Remainder  output  WIDTH  result remainder (HI); held until next Done
DivZero  output  1  last operation had Divisor == 0; held until next Done

Behaviour:
- Clocking and reset: single clock domain. Reset is synchronous and active-high, and wins over every other input on the same edge.
- On Reset: state=IDLE; Busy=0, Done=0, Quotient=0, Remainder=0, DivZero=0; counter=0.
- Reset mid-operation aborts the operation with no Done pulse. The first Start after reset deasserts is accepted normally.
- FSM states: IDLE, RUN, FIX.
- IDLE:
  - Start=0: stay in IDLE.
  - Start=1: go to RUN. Busy=1 from the next cycle.
  - On that edge, latch the magnitudes: |Dividend| into Q-reg and |Divisor| into D-reg. When Signed=0, the raw values are used.
  - Latch negQ = Signed & (Dividend[W-1] ^ Divisor[W-1]) and negR = Signed & Dividend[W-1].
  - Latch dz = (Divisor == 0).
  - Clear the partial remainder P (WIDTH+1 bits); set counter = WIDTH-1.
- RUN, one iteration per edge:
  - {P,Q} shifted left 1 (Q[W-1] enters P[0]).
  - T = P_shifted - {0,D}.
  - If T >= 0 (MSB clear): P=T, Q[0]=1. Otherwise P is kept and Q[0]=0.
  - Counter decrements. The edge with counter==0 performs the last iteration and goes to FIX.
- FIX, one cycle; its outgoing edge does all of the following:
  - Quotient = negQ ? -Q : Q; Remainder = negR ? -P[W-1:0] : P[W-1:0].
  - If dz: Quotient = all ones, Remainder = original Dividend (raw, unsigned or signed alike), DivZero = 1. Otherwise DivZero = 0.
  - Done=1 for exactly one cycle; Busy=0; state=IDLE.
- Latency: Start sampled at edge E; Done high in the cycle after edge E+WIDTH+1 (33 clocks for WIDTH=32). Latency is fixed, including the divide-by-zero case.
- Start while Busy=1: ignored, with no queuing or effect on the operation in progress.
- Start high in the same cycle as Done: accepted, because the state is IDLE; back-to-back throughput is one result per WIDTH+2 cycles.
- Operand inputs may change freely after the Start edge; only latched copies are used.
- Signed overflow (most-negative / -1): magnitude wraps naturally, giving Quotient = 0x80000000 and Remainder = 0 for WIDTH=32. No flag is raised.
- Remainder sign follows the dividend; |Remainder| < |Divisor| for Divisor != 0.
- Outputs are registered only, with no combinational paths from inputs to outputs.

Test Plan:
- DIVU 100/7: Start with Signed=0, Dividend=100, Divisor=7 -> Busy high for 33 cycles; Done pulse 1 cycle; Quotient=14, Remainder=2, DivZero=0.
- DIV -7/2: Dividend=0xFFFFFFF9, Divisor=2, Signed=1 -> Quotient=0xFFFFFFFD (-3), Remainder=0xFFFFFFFF (-1). Then DIV 7/-2 -> Quotient=0xFFFFFFFD, Remainder=1.
- Divide by zero: Dividend=0x00001234, Divisor=0, both Signed=0 and Signed=1 -> Done still at 33 cycles; Quotient=0xFFFFFFFF, Remainder=0x00001234, DivZero=1.
- Overflow and extremes:
  - DIV 0x80000000 / 0xFFFFFFFF -> Quotient=0x80000000, Remainder=0.
  - DIVU 0xFFFFFFFF / 1 -> Quotient=0xFFFFFFFF, Remainder=0.
  - DIVU 5/9 -> Quotient=0, Remainder=5.
- Handshake:
  - Pulse Start again at cycle 10 of an operation with different operands -> ignored; the original result is produced.
  - Assert Start in the Done cycle with 81/9 -> accepted; second Done 34 cycles after the first with Quotient=9, Remainder=0.
- Reset mid-op: assert Reset at iteration 15 -> next cycle Busy=0, Done=0, Quotient=Remainder=0, DivZero=0. No Done appears later. A new Start of 10/3 completes normally with Quotient=3, Remainder=1.
